// File: rtl/flash_io_pkg.sv
// rtl/flash_io_pkg.sv - shared mode/state types and lane helpers for the QSPI byte shifter
package flash_io_pkg;

  typedef enum logic [1:0] {
    MODE_SINGLE = 2'b00,
    MODE_DUAL   = 2'b01,
    MODE_QUAD   = 2'b10
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_TURN     = 2'b01,
    ST_SHIFT    = 2'b10,
    ST_RSP_WAIT = 2'b11
  } state_e;

  // Number of pad lanes carrying data per flash_clk beat.
  function automatic logic [2:0] lanes_of(input mode_e mode);
    logic [2:0] l;
    l = 3'd1;
    case (mode)
      MODE_DUAL: l = 3'd2;
      MODE_QUAD: l = 3'd4;
      default:   l = 3'd1;
    endcase
    return l;
  endfunction

  // The unused encoding 2'b11 behaves as single-lane.
  function automatic mode_e norm_mode(input logic [1:0] m);
    return (m == 2'b11) ? MODE_SINGLE : mode_e'(m);
  endfunction

endpackage

// File: rtl/flash_io_clkgen.sv
// rtl/flash_io_clkgen.sv - flash_clk half-period divider with end-of-phase strobes
module flash_io_clkgen
  import flash_io_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic gate,
  output logic flash_clk,
  output logic fall_stb,
  output logic rise_stb
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          phase;
  logic          wrap;

  assign wrap     = (cnt == CW'(CLK_DIV - 1));
  // rise_stb marks the edge that ends a low phase, fall_stb the edge ending a high phase
  assign rise_stb = en && wrap && !phase;
  assign fall_stb = en && wrap && phase;

  // Phase counter; flash_clk only toggles when gated on, so TURN idles with the clock low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      phase     <= 1'b0;
      flash_clk <= 1'b0;
    end else if (!en) begin
      cnt       <= '0;
      phase     <= 1'b0;
      flash_clk <= 1'b0;
    end else if (wrap) begin
      cnt       <= '0;
      phase     <= !phase;
      flash_clk <= gate && !phase;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/flash_io_shifter.sv
// rtl/flash_io_shifter.sv - QSPI single/dual/quad byte shifter; FLASH_IO_SHIFTER_CS_EN adds chip select
module flash_io_shifter
  import flash_io_pkg::*;
#(
  parameter int IO_WIDTH   = 4,
  parameter int DATA_W     = 8,
  parameter int CLK_DIV    = 1,
  parameter int TURNAROUND = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [DATA_W-1:0]   cmd_data,
  input  logic                cmd_dir,
  input  logic [1:0]          cmd_mode,
`ifdef FLASH_IO_SHIFTER_CS_EN
  input  logic                cmd_last,
  output logic                flash_csn,
`endif
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                busy,
  output logic                flash_clk,
  output logic [IO_WIDTH-1:0] flash_io_do,
  output logic [IO_WIDTH-1:0] flash_io_oe,
  input  logic [IO_WIDTH-1:0] flash_io_di
);

  localparam int BW = $clog2(DATA_W) + 1;
  localparam int TW = $clog2(TURNAROUND + 1) + 1;

  state_e            state;
  mode_e             mode_q;
  mode_e             nm;
  logic              dir_q;
  logic              prev_write;
  logic              rsp_pend;
  logic [DATA_W-1:0] sr;
  logic [BW-1:0]     beat_cnt;
  logic [TW-1:0]     turn_cnt;
  logic              fall_stb;
  logic              rise_stb;
  logic              accept;
  logic              shift_end;
  logic              turn;
  logic              ready_ok;

  // Top lanes of the shift register, MSB-first, mapped onto the low pad lanes.
  function automatic logic [3:0] beat_out(input mode_e m, input logic [DATA_W-1:0] d);
    case (m)
      MODE_QUAD: return d[DATA_W-1 -: 4];
      MODE_DUAL: return {2'b00, d[DATA_W-1 -: 2]};
      default:   return {3'b000, d[DATA_W-1]};
    endcase
  endfunction

  // Single mode reads MISO on lane 1; dual/quad read lanes from 0 upward.
  function automatic logic [3:0] sample_in(input mode_e m, input logic [IO_WIDTH-1:0] di);
    case (m)
      MODE_QUAD: return di[3:0];
      MODE_DUAL: return {2'b00, di[1:0]};
      default:   return {3'b000, di[1]};
    endcase
  endfunction

  // Single mode always drives MOSI; dual/quad drive lanes only when writing.
  function automatic logic [3:0] oe_of(input mode_e m, input logic dir);
    case (m)
      MODE_QUAD: return dir ? 4'b0000 : 4'b1111;
      MODE_DUAL: return dir ? 4'b0000 : 4'b0011;
      default:   return 4'b0001;
    endcase
  endfunction

  assign nm        = norm_mode(cmd_mode);
  assign accept    = (state == ST_IDLE) && cmd_valid && cmd_ready;
  assign shift_end = (state == ST_SHIFT) && fall_stb && (beat_cnt == '0);
  assign busy      = (state == ST_TURN) || (state == ST_SHIFT);
  assign turn      = cmd_dir && (nm != MODE_SINGLE) && prev_write && (TURNAROUND > 0);

  flash_io_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk       (clk),
    .rst       (rst),
    .en        (busy),
    .gate      (state == ST_SHIFT),
    .flash_clk (flash_clk),
    .fall_stb  (fall_stb),
    .rise_stb  (rise_stb)
  );

  // Command FSM: accept, optional turnaround, beat shifting and response hand-off
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      mode_q      <= MODE_SINGLE;
      dir_q       <= 1'b0;
      prev_write  <= 1'b0;
      rsp_pend    <= 1'b0;
      sr          <= '0;
      beat_cnt    <= '0;
      turn_cnt    <= '0;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      flash_io_do <= '0;
      flash_io_oe <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            mode_q      <= nm;
            dir_q       <= cmd_dir;
            prev_write  <= !cmd_dir;
            cmd_ready   <= 1'b0;
            beat_cnt    <= BW'(DATA_W / lanes_of(nm) - 1);
            turn_cnt    <= TW'(TURNAROUND - 1);
            flash_io_oe <= IO_WIDTH'(oe_of(nm, cmd_dir));
            if (cmd_dir) begin
              sr          <= '0;
              flash_io_do <= '0;
            end else begin
              sr          <= cmd_data << lanes_of(nm);
              flash_io_do <= IO_WIDTH'(beat_out(nm, cmd_data));
            end
            state <= turn ? ST_TURN : ST_SHIFT;
          end else if (rsp_pend) begin
            rsp_pend  <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_data  <= sr;
            state     <= ST_RSP_WAIT;
          end else begin
            cmd_ready <= ready_ok;
          end
        end
        ST_TURN: begin
          if (fall_stb) begin
            if (turn_cnt == '0) state <= ST_SHIFT;
            else turn_cnt <= turn_cnt - 1'b1;
          end
        end
        ST_SHIFT: begin
          if (rise_stb && dir_q)
            sr <= (sr << lanes_of(mode_q)) | DATA_W'(sample_in(mode_q, flash_io_di));
          if (fall_stb) begin
            if (beat_cnt == '0) begin
              state       <= ST_IDLE;
              flash_io_oe <= '0;
              flash_io_do <= '0;
              rsp_pend    <= dir_q;
            end else begin
              beat_cnt <= beat_cnt - 1'b1;
              if (!dir_q) begin
                flash_io_do <= IO_WIDTH'(beat_out(mode_q, sr));
                sr          <= sr << lanes_of(mode_q);
              end
            end
          end
        end
        ST_RSP_WAIT: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= ready_ok;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef FLASH_IO_SHIFTER_CS_EN
  localparam int GW = $clog2(2 * CLK_DIV + 1) + 1;

  logic          last_q;
  logic          csn_pend;
  logic [GW-1:0] gap;

  assign ready_ok = !csn_pend && (gap == '0);

  // Chip select: low from first accept, released after the last command plus a minimum idle gap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flash_csn <= 1'b1;
      last_q    <= 1'b0;
      csn_pend  <= 1'b0;
      gap       <= '0;
    end else begin
      if (accept) begin
        flash_csn <= 1'b0;
        last_q    <= cmd_last;
      end
      if (shift_end && last_q) csn_pend <= 1'b1;
      if (csn_pend) begin
        csn_pend  <= 1'b0;
        flash_csn <= 1'b1;
        gap       <= GW'(2 * CLK_DIV);
      end else if (gap != '0) begin
        gap <= gap - 1'b1;
      end
    end
  end
`else
  logic unused_end;
  assign unused_end = shift_end;
  assign ready_ok   = 1'b1;
`endif

endmodule

// File: doc/flash_io_shifter.md
Name: flash_io_shifter

Overview:
Parametrised QSPI byte shifter; next generation of the flash pad wrapper.
- Drives the SB_IO pad vectors (do/oe/di) and generates flash_clk.
- Serialises command/data bytes in single, dual or quad lane mode, with a valid/ready front end and a read-response channel.
- Inserts a bus-turnaround when lanes change from driven to sampled.
- Sits between the flash controller FSM and the bidirectional pad wrapper.

Parameters:
IO_WIDTH, 4, pad lanes; must be >= 4 for quad mode.
DATA_W, 8, bits per command; must be divisible by 4.
CLK_DIV, 1, flash_clk half-period in clk cycles (>= 1).
TURNAROUND, 1, idle flash_clk periods inserted on write-to-read change in dual/quad mode.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  shifter can accept a command
cmd_data  in  DATA_W  write data, MSB first (ignored for reads)
cmd_dir  in  1  0 = write, 1 = read
cmd_mode  in  2  00 single, 01 dual, 10 quad; 11 is treated as single
rsp_valid  out  1  read data available
rsp_ready  in  1  read data consumed
rsp_data  out  DATA_W  captured read byte
busy  out  1  shift or turnaround in progress
flash_clk  out  1  SPI clock, mode 0
flash_io_do  out  IO_WIDTH  pad output data
flash_io_oe  out  IO_WIDTH  pad output enables
flash_io_di  in  IO_WIDTH  pad input data

Behaviour:
- Clock and reset: single clk domain. rst is asynchronous, active-high.
- Reset values: all outputs 0, including cmd_ready, rsp_valid, rsp_data, busy, flash_clk, do and oe.
- After reset: cmd_ready rises on the first clk edge after rst deasserts.
- Reset mid-transfer: immediately forces the reset values. No partial rsp is ever emitted.
- State machine: IDLE -> (TURN) -> SHIFT -> IDLE, plus RSP_WAIT.
- IDLE:
  - cmd_ready = !rsp_valid.
  - Accept on cmd_valid && cmd_ready; latch data, dir and mode; cmd_ready drops the next cycle.
- Lanes per beat L: 1, 2 or 4. Beats = DATA_W/L.
- Single mode:
  - MOSI = lane0; oe[0] = 1 for the whole transfer.
  - MISO is sampled from lane1.
- Dual/quad write: oe[L-1:0] = 1.
- Dual/quad read: oe = 0.
- Unused lanes: oe = 0, do = 0.
- TURN:
  - Entered on accept when the new dir = read, the mode is dual or quad, and the previous command was a write.
  - Holds flash_clk low and oe = 0 for TURNAROUND*2*CLK_DIV cycles.
- SHIFT, per beat:
  - Low phase of CLK_DIV cycles, with do updated at the start of the phase.
  - High phase of CLK_DIV cycles; flash_di is sampled into the shift register on the rising flash_clk edge, lower lanes carrying lower bits.
  - After the last high phase, flash_clk returns low and oe is cleared.
- Latency: accept to cmd_ready/rsp_valid = 2*Beats*CLK_DIV + 1 cycles, plus the TURN time when TURN is inserted.
- Read response: rsp_valid rises with rsp_data stable and holds until rsp_ready. The state is RSP_WAIT while rsp_valid && !rsp_ready.
- Simultaneous rsp handshake and new cmd_valid: cmd_ready rises the cycle after rsp_ready is seen.
- Writes produce no response.
- busy: 1 in TURN and SHIFT.

Optional Feature:
Macro FLASH_IO_SHIFTER_CS_EN.
- When defined:
  - Adds input cmd_last and output flash_csn (reset 1).
  - flash_csn falls in the cycle after the first accept and stays low across commands.
  - It rises 1 cycle after the SHIFT end of the command flagged cmd_last, and stays high for at least 2*CLK_DIV cycles before the next accept. cmd_ready is held low during that time.
- When undefined: neither port exists; chip select is owned by the controller.

Decomposition:
- Package flash_io_pkg holds:
  - the mode enum (MODE_SINGLE, MODE_DUAL, MODE_QUAD);
  - the state enum;
  - the lanes_of(mode) function returning 1/2/4.
- One sub-module, flash_io_clkgen: CLK_DIV half-period counter giving fall_stb/rise_stb strobes and flash_clk. It is reused by TURN and SHIFT.

Test Plan:
- Quad write, CLK_DIV=1, cmd_data=0xA5:
  - do[3:0] = 0xA then 0x5, oe = 0xF.
  - 2 flash_clk pulses; cmd_ready returns 5 cycles after accept.
- Single read, flash_di[1] bitstream 1,0,1,1,0,0,1,0:
  - rsp_data = 0xB2 after 8 pulses.
  - oe = 0x1 throughout; rsp_valid held until rsp_ready.
- Quad write then quad read, TURNAROUND=1, CLK_DIV=2:
  - 4 cycles with oe = 0 and flash_clk low before the first read pulse.
  - Read of di nibbles 3, C gives rsp_data = 0x3C.
- Read with rsp_ready low for 10 cycles:
  - rsp_valid/rsp_data stable and cmd_ready = 0 throughout.
  - cmd_ready = 1 the cycle after rsp_ready.
- rst asserted mid-beat of a dual write:
  - All outputs 0 asynchronously; after release, the next command shifts correctly from beat 0.
- With FLASH_IO_SHIFTER_CS_EN, two writes, second with cmd_last = 1:
  - flash_csn low across both, high 1 cycle after the second ends.
  - No accept for 2*CLK_DIV cycles afterwards.
